// File: rtl/median6_stream_ctrl.sv
// Streaming 6-sample median controller: fills an arrival-ordered window over a
// valid/ready input, then presents the floor-averaged median with backpressure.
module median6_stream_ctrl #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mode,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] median,
  output logic [2:0]        fill_cnt
);

  typedef enum logic [1:0] {FILL, CALC, HOLD} state_t;

  state_t                  state_q, state_nxt;
  logic [5:0][DATA_W-1:0]  win_q;
  logic [2:0]              fill_q;
  logic                    mode_q;
  logic                    out_valid_q;
  logic [DATA_W-1:0]       median_q;
  logic                    in_xfer, out_xfer;

  // Floor of the mean using a sum one bit wider than the operands.
  function automatic logic [DATA_W-1:0] avg_floor(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic [DATA_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[DATA_W:1];
  endfunction

  function automatic logic [DATA_W-1:0] median6(input logic [5:0][DATA_W-1:0] w);
    logic [5:0][DATA_W-1:0] s;
    logic [DATA_W-1:0]      t;
    s = w;
    for (int i = 0; i < 5; i++) begin
      for (int j = 0; j < 5 - i; j++) begin
        if (s[j] > s[j+1]) begin
          t      = s[j];
          s[j]   = s[j+1];
          s[j+1] = t;
        end
      end
    end
    return avg_floor(s[2], s[3]);
  endfunction

  assign in_ready  = (state_q == FILL);
  assign out_valid = out_valid_q;
  assign median    = median_q;
  assign fill_cnt  = fill_q;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FILL;
    else        state_q <= state_nxt;
  end

  // A transfer at 5 completes the window; a transfer at 6 is a sliding update.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      FILL:    if (in_xfer && fill_q >= 3'd5) state_nxt = CALC;
      CALC:    state_nxt = HOLD;
      HOLD:    if (out_xfer) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
    if (flush) state_nxt = FILL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q       <= '0;
      fill_q      <= 3'd0;
      mode_q      <= 1'b0;
      out_valid_q <= 1'b0;
      median_q    <= '0;
    end else begin
      // Mode is only picked up while the window is empty.
      if (state_q == FILL && fill_q == 3'd0) mode_q <= mode;
      if (flush) begin
        fill_q      <= 3'd0;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          FILL: begin
            if (in_xfer) begin
              if (fill_q < 3'd6) begin
                win_q[fill_q] <= in_data;
                fill_q        <= fill_q + 3'd1;
              end else begin
                for (int i = 0; i < 5; i++) win_q[i] <= win_q[i+1];
                win_q[5] <= in_data;
              end
            end
          end
          CALC: begin
            median_q    <= median6(win_q);
            out_valid_q <= 1'b1;
          end
          HOLD: begin
            if (out_xfer) begin
              out_valid_q <= 1'b0;
              if (!mode_q) fill_q <= 3'd0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_median6_stream_ctrl.sv
// Bench for median6_stream_ctrl: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level window/median model.
module tb_median6_stream_ctrl;
  localparam int DATA_W = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              mode, flush, in_valid, out_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] median;
  logic [2:0]        fill_cnt;

  median6_stream_ctrl #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .flush(flush),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .median(median),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: window as an arrival-ordered queue plus pending/holding flags.
  int mq[$];
  bit m_calc, m_hold, m_mode;
  int m_med;

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_median(input int w[$]);
    int s[$];
    s = w;
    s.sort();
    return (s[2] + s[3]) / 2;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_calc = 0;
    m_hold = 0;
    m_mode = 0;
    m_med  = 0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!m_calc && !m_hold && mq.size() == 0) m_mode = mode;
    if (flush) begin
      mq.delete();
      m_calc = 0;
      m_hold = 0;
    end else if (m_calc) begin
      m_med  = ref_median(mq);
      m_calc = 0;
      m_hold = 1;
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 0;
        if (!m_mode) mq.delete();
      end
    end else if (in_valid) begin
      if (mq.size() == 6) void'(mq.pop_front());
      mq.push_back(int'(in_data));
      if (mq.size() == 6) m_calc = 1;
    end
    #1;
    check("in_ready",  int'(in_ready),  int'(!(m_calc || m_hold)));
    check("out_valid", int'(out_valid), int'(m_hold));
    check("fill_cnt",  int'(fill_cnt),  mq.size());
    check("median",    int'(median),    m_med);
  endtask

  task automatic send(input int v);
    bit acc;
    acc      = 0;
    in_valid = 1'b1;
    in_data  = DATA_W'(v);
    for (int k = 0; k < 20 && !acc; k++) begin
      acc = !(m_calc || m_hold);
      step();
    end
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send6(input int a, input int b, input int c,
                       input int d, input int e, input int f);
    send(a); send(b); send(c); send(d); send(e); send(f);
  endtask

  task automatic expect_med(input string tag, input int exp);
    for (int i = 0; i < 8 && !out_valid; i++) step();
    check({tag, "_vld"}, int'(out_valid), 1);
    check(tag, int'(median), exp);
  endtask

  initial begin
    rst_n = 1'b0; mode = 1'b0; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; in_data = '0;
    model_reset();
    #12;
    check("rst_in_ready",  int'(in_ready),  1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_median",    int'(median),    0);
    check("rst_fill",      int'(fill_cnt),  0);
    rst_n = 1'b1;
    step();

    // Block mode, one-cycle output with immediate acceptance
    send6(3, 1, 4, 1, 5, 9);
    expect_med("t1_med", 3);
    step();
    check("t1_vld_drop", int'(out_valid), 0);
    check("t1_fill0",    int'(fill_cnt),  0);

    // Sum must not wrap at DATA_W bits
    send6(15, 15, 15, 14, 14, 0);
    expect_med("t2_med", 14);
    step();

    // Backpressure holds the result
    out_ready = 1'b0;
    send6(3, 1, 4, 1, 5, 9);
    expect_med("t3_med", 3);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t3_hold_med", int'(median),    3);
      check("t3_hold_vld", int'(out_valid), 1);
      check("t3_hold_rdy", int'(in_ready),  0);
    end
    out_ready = 1'b1;
    step();
    check("t3_single_xfer", int'(out_valid), 0);

    // Sliding mode
    mode = 1'b1;
    send6(3, 1, 4, 1, 5, 9);
    expect_med("t4_med0", 3);
    step();
    send(2);
    expect_med("t4_med1", 3);
    step();
    send(6);
    expect_med("t4_med2", 4);
    step();
    check("t4_fill6", int'(fill_cnt), 6);
    flush = 1'b1; step(); flush = 1'b0;
    mode = 1'b0;

    // Flush drops the in-flight sample and restarts the window
    send(1); send(2); send(3); send(4);
    flush = 1'b1; in_valid = 1'b1; in_data = 4'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t5_fill0", int'(fill_cnt), 0);
    send6(2, 2, 2, 8, 8, 8);
    expect_med("t5_med", 5);
    step();

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    send6(3, 1, 4, 1, 5, 9);
    expect_med("t6_pre", 3);
    #2 rst_n = 1'b0;
    #1;
    check("t6_vld",  int'(out_valid), 0);
    check("t6_med",  int'(median),    0);
    check("t6_fill", int'(fill_cnt),  0);
    model_reset();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("t6_rdy", int'(in_ready), 1);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DATA_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      mode      = $urandom_range(0, 1) == 1;
      flush     = ($urandom_range(0, 59) == 0);
      step();
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
